// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: main instruction FSM, ALU decode, memory wait
// handshake with timeout, optional bne/andi/ori, illegal-op and bus-error pulses.
module mips_mc_ctrl #(
    parameter bit          EXT_EN   = 1'b1,
    parameter bit          MEM_WAIT = 1'b1,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       memreq,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic       extop,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       illegal,
    output logic       buserr,
    output logic [3:0] state_o
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BREX    = 4'd8,
        IMMEX   = 4'd9,
        IMMWB   = 4'd10,
        JEX     = 4'd11
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          ready;
    logic          wait_st;
    logic          timeout;
    logic          is_bne;
    logic          is_andi;
    logic          is_ori;

    assign ready   = MEM_WAIT ? mem_ready : 1'b1;
    assign wait_st = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    // Ready wins over timeout: timeout only fires while ready is low.
    assign timeout = wait_st && !ready && (wcnt_q == CW'(MAX_WAIT));
    assign wcnt_d  = (wait_st && !ready && !timeout) ? wcnt_q + CW'(1) : '0;

    assign is_bne  = EXT_EN && (op == OP_BNE);
    assign is_andi = EXT_EN && (op == OP_ANDI);
    assign is_ori  = EXT_EN && (op == OP_ORI);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FETCH;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        memreq     = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = 3'b000;
        extop      = 1'b1;
        pcsrc      = 2'b00;
        pcen       = 1'b0;
        illegal    = 1'b0;
        buserr     = 1'b0;
        state_o    = 4'(state_q);

        case (state_q)
            FETCH: begin
                memreq     = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                if (ready) begin
                    irwrite = 1'b1;
                    pcen    = 1'b1;
                    state_d = DECODE;
                end else if (timeout) begin
                    buserr = 1'b1;
                end
            end
            DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
                if ((op == OP_LW) || (op == OP_SW)) begin
                    state_d = MEMADR;
                end else if (op == OP_RTYPE) begin
                    state_d = RTYPEEX;
                end else if ((op == OP_BEQ) || is_bne) begin
                    state_d = BREX;
                end else if ((op == OP_ADDI) || is_andi || is_ori) begin
                    state_d = IMMEX;
                end else if (op == OP_J) begin
                    state_d = JEX;
                end else begin
                    illegal = 1'b1;
                    state_d = FETCH;
                end
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                state_d    = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                memreq = 1'b1;
                iord   = 1'b1;
                if (ready) begin
                    state_d = MEMWB;
                end else if (timeout) begin
                    buserr  = 1'b1;
                    state_d = FETCH;
                end
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                memreq   = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                if (ready) begin
                    state_d = FETCH;
                end else if (timeout) begin
                    buserr  = 1'b1;
                    state_d = FETCH;
                end
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                state_d = RTYPEWB;
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            BREX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = is_bne ? ~zero : zero;
                state_d    = FETCH;
            end
            IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (is_andi) begin
                    alucontrol = ALU_AND;
                    extop      = 1'b0;
                end else if (is_ori) begin
                    alucontrol = ALU_OR;
                    extop      = 1'b0;
                end else begin
                    alucontrol = ALU_ADD;
                end
                state_d = IMMWB;
            end
            IMMWB: begin
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcen    = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Reset masks every strobe and presents the idle FETCH datapath setup.
        if (!reset) begin
            state_d    = FETCH;
            memreq     = 1'b0;
            iord       = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            regdst     = 1'b0;
            memtoreg   = 1'b0;
            regwrite   = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = 2'b01;
            alucontrol = ALU_ADD;
            extop      = 1'b1;
            pcsrc      = 2'b00;
            pcen       = 1'b0;
            illegal    = 1'b0;
            buserr     = 1'b0;
            state_o    = 4'd0;
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: two configurations driven from per-instruction
// expected-cycle plans derived from the instruction latency/output rules.
module tb_mips_mc_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       memreq;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluc;
        logic       extop;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       illegal;
        logic       buserr;
    } out_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       rdy;
        logic       rst;
        out_t       exp;
    } rec_t;

    localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,
                           S_MEMRD = 4'd3,  S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,
                           S_RTEX  = 4'd6,  S_RTWB   = 4'd7,  S_BREX   = 4'd8,
                           S_IMMEX = 4'd9,  S_IMMWB  = 4'd10, S_JEX    = 4'd11;

    localparam logic [5:0] LW = 6'h23, SW = 6'h2b, RT = 6'h00, BEQ = 6'h04, BNE = 6'h05,
                           ADDI = 6'h08, ANDI = 6'h0c, ORI = 6'h0d, JMP = 6'h02;

    logic       clk = 1'b0;
    logic       reset_v    [2];
    logic [5:0] op_v       [2];
    logic [5:0] funct_v    [2];
    logic       zero_v     [2];
    logic       rdy_v      [2];
    logic       memreq_v   [2];
    logic       iord_v     [2];
    logic       memwrite_v [2];
    logic       irwrite_v  [2];
    logic       regdst_v   [2];
    logic       memtoreg_v [2];
    logic       regwrite_v [2];
    logic       alusrca_v  [2];
    logic [1:0] alusrcb_v  [2];
    logic [2:0] aluc_v     [2];
    logic       extop_v    [2];
    logic [1:0] pcsrc_v    [2];
    logic       pcen_v     [2];
    logic       illegal_v  [2];
    logic       buserr_v   [2];
    logic [3:0] state_v    [2];
    out_t       obs        [2];

    int   vectors     = 0;
    int   miscompares = 0;
    rec_t plan_q[$];

    always #5 clk = ~clk;

    // dut0: extended ISA, handshake honoured, short timeout
    mips_mc_ctrl #(.EXT_EN(1'b1), .MEM_WAIT(1'b1), .MAX_WAIT(3)) dut0 (
        .clk(clk), .reset(reset_v[0]), .op(op_v[0]), .funct(funct_v[0]), .zero(zero_v[0]),
        .mem_ready(rdy_v[0]), .memreq(memreq_v[0]), .iord(iord_v[0]), .memwrite(memwrite_v[0]),
        .irwrite(irwrite_v[0]), .regdst(regdst_v[0]), .memtoreg(memtoreg_v[0]),
        .regwrite(regwrite_v[0]), .alusrca(alusrca_v[0]), .alusrcb(alusrcb_v[0]),
        .alucontrol(aluc_v[0]), .extop(extop_v[0]), .pcsrc(pcsrc_v[0]), .pcen(pcen_v[0]),
        .illegal(illegal_v[0]), .buserr(buserr_v[0]), .state_o(state_v[0]));

    // dut1: base ISA, mem_ready ignored
    mips_mc_ctrl #(.EXT_EN(1'b0), .MEM_WAIT(1'b0), .MAX_WAIT(15)) dut1 (
        .clk(clk), .reset(reset_v[1]), .op(op_v[1]), .funct(funct_v[1]), .zero(zero_v[1]),
        .mem_ready(rdy_v[1]), .memreq(memreq_v[1]), .iord(iord_v[1]), .memwrite(memwrite_v[1]),
        .irwrite(irwrite_v[1]), .regdst(regdst_v[1]), .memtoreg(memtoreg_v[1]),
        .regwrite(regwrite_v[1]), .alusrca(alusrca_v[1]), .alusrcb(alusrcb_v[1]),
        .alucontrol(aluc_v[1]), .extop(extop_v[1]), .pcsrc(pcsrc_v[1]), .pcen(pcen_v[1]),
        .illegal(illegal_v[1]), .buserr(buserr_v[1]), .state_o(state_v[1]));

    assign obs[0] = {state_v[0], memreq_v[0], iord_v[0], memwrite_v[0], irwrite_v[0],
                     regdst_v[0], memtoreg_v[0], regwrite_v[0], alusrca_v[0], alusrcb_v[0],
                     aluc_v[0], extop_v[0], pcsrc_v[0], pcen_v[0], illegal_v[0], buserr_v[0]};
    assign obs[1] = {state_v[1], memreq_v[1], iord_v[1], memwrite_v[1], irwrite_v[1],
                     regdst_v[1], memtoreg_v[1], regwrite_v[1], alusrca_v[1], alusrcb_v[1],
                     aluc_v[1], extop_v[1], pcsrc_v[1], pcen_v[1], illegal_v[1], buserr_v[1]};

    function automatic bit ext_en(input int d);   return d == 0; endfunction
    function automatic bit mem_wait(input int d); return d == 0; endfunction
    function automatic int max_wait(input int d); return (d == 0) ? 3 : 15; endfunction

    // Moore-level outputs of each state as listed in the operation table
    function automatic out_t base_out(input logic [3:0] st);
        out_t e = '0;
        e.st = st;
        e.extop = 1'b1;
        case (st)
            S_FETCH:  begin e.memreq = 1; e.alusrcb = 2'b01; e.aluc = 3'b010; end
            S_DECODE: begin e.alusrcb = 2'b11; e.aluc = 3'b010; end
            S_MEMADR: begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluc = 3'b010; end
            S_MEMRD:  begin e.memreq = 1; e.iord = 1; end
            S_MEMWB:  begin e.memtoreg = 1; e.regwrite = 1; end
            S_MEMWR:  begin e.memreq = 1; e.iord = 1; e.memwrite = 1; end
            S_RTEX:   e.alusrca = 1;
            S_RTWB:   begin e.regdst = 1; e.regwrite = 1; end
            S_BREX:   begin e.alusrca = 1; e.aluc = 3'b110; e.pcsrc = 2'b01; end
            S_IMMEX:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
            S_IMMWB:  e.regwrite = 1;
            S_JEX:    begin e.pcsrc = 2'b10; e.pcen = 1; end
            default:  ;
        endcase
        return e;
    endfunction

    function automatic out_t rst_vec();
        out_t e = base_out(S_FETCH);
        e.memreq = 1'b0;
        return e;
    endfunction

    task automatic push(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                        input logic rdy, input logic rst, input out_t e);
        rec_t r;
        r.op = op; r.funct = funct; r.zero = zero; r.rdy = rdy; r.rst = rst; r.exp = e;
        plan_q.push_back(r);
    endtask

    task automatic plan_reset(input int n);
        for (int i = 0; i < n; i++)
            push(6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 1'b0, rst_vec());
    endtask

    // One memory phase: 'waits' low-ready cycles before ready, bounded by MAX_WAIT
    task automatic plan_mem(input int d, input logic [3:0] st, input int waits,
                            input logic [5:0] op, input logic [5:0] funct, input logic zero,
                            output bit timed_out);
        bit   done = 0;
        int   k = 0;
        out_t e;
        timed_out = 0;
        while (!done) begin
            bit   rin  = (k >= waits);
            bit   reff = mem_wait(d) ? rin : 1'b1;
            logic drv  = mem_wait(d) ? rin : 1'($urandom);
            e = base_out(st);
            if (reff) begin
                if (st == S_FETCH) begin e.irwrite = 1; e.pcen = 1; end
                done = 1;
            end else if (k == max_wait(d)) begin
                e.buserr = 1;
                timed_out = 1;
                done = 1;
            end
            push(op, funct, zero, drv, 1'b1, e);
            k++;
        end
    endtask

    task automatic plan_instr(input int d, input logic [5:0] op, input logic [5:0] funct,
                              input logic zero, input int wf, input int wm);
        bit   to;
        out_t e;
        bit   bne_ok  = ext_en(d) && op == BNE;
        bit   andi_ok = ext_en(d) && op == ANDI;
        bit   ori_ok  = ext_en(d) && op == ORI;
        plan_mem(d, S_FETCH, wf, op, funct, zero, to);
        if (to) plan_mem(d, S_FETCH, 0, op, funct, zero, to);
        e = base_out(S_DECODE);
        if (!(op == LW || op == SW || op == RT || op == BEQ || bne_ok || op == ADDI ||
              andi_ok || ori_ok || op == JMP)) begin
            e.illegal = 1;
            push(op, funct, zero, 1'($urandom), 1'b1, e);
            return;
        end
        push(op, funct, zero, 1'($urandom), 1'b1, e);
        if (op == LW || op == SW) begin
            push(op, funct, zero, 1'($urandom), 1'b1, base_out(S_MEMADR));
            plan_mem(d, (op == LW) ? S_MEMRD : S_MEMWR, wm, op, funct, zero, to);
            if (op == LW && !to) push(op, funct, zero, 1'($urandom), 1'b1, base_out(S_MEMWB));
        end else if (op == RT) begin
            e = base_out(S_RTEX);
            case (funct)
                6'h20:   e.aluc = 3'b010;
                6'h22:   e.aluc = 3'b110;
                6'h24:   e.aluc = 3'b000;
                6'h25:   e.aluc = 3'b001;
                6'h2a:   e.aluc = 3'b111;
                default: e.illegal = 1;
            endcase
            push(op, funct, zero, 1'($urandom), 1'b1, e);
            if (!e.illegal) push(op, funct, zero, 1'($urandom), 1'b1, base_out(S_RTWB));
        end else if (op == BEQ || bne_ok) begin
            e = base_out(S_BREX);
            e.pcen = bne_ok ? ~zero : zero;
            push(op, funct, zero, 1'($urandom), 1'b1, e);
        end else if (op == JMP) begin
            push(op, funct, zero, 1'($urandom), 1'b1, base_out(S_JEX));
        end else begin
            e = base_out(S_IMMEX);
            if (andi_ok)     begin e.aluc = 3'b000; e.extop = 0; end
            else if (ori_ok) begin e.aluc = 3'b001; e.extop = 0; end
            else                   e.aluc = 3'b010;
            push(op, funct, zero, 1'($urandom), 1'b1, e);
            push(op, funct, zero, 1'($urandom), 1'b1, base_out(S_IMMWB));
        end
    endtask

    task automatic tick(input int d, input rec_t r, output out_t got);
        op_v[d] = r.op; funct_v[d] = r.funct; zero_v[d] = r.zero;
        rdy_v[d] = r.rdy; reset_v[d] = r.rst;
        @(negedge clk);
        got = obs[d];
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 11))
            0: return LW;   1: return SW;   2: return RT;   3: return BEQ;
            4: return BNE;  5: return ADDI; 6: return ANDI; 7: return ORI;
            8: return JMP;  9: return 6'h3f; 10: return 6'h01; default: return 6'h0f;
        endcase
    endfunction

    function automatic logic [5:0] pick_funct();
        case ($urandom_range(0, 6))
            0: return 6'h20; 1: return 6'h22; 2: return 6'h24; 3: return 6'h25;
            4: return 6'h2a; 5: return 6'h00; default: return 6'h3f;
        endcase
    endfunction

    task automatic test_reset();
        out_t got;
        for (int d = 0; d < 2; d++) begin
            plan_reset(3);
            plan_instr(d, JMP, 6'h00, 1'b0, 1, 0);
            while (plan_q.size() > 0) begin
                rec_t r = plan_q.pop_front();
                tick(d, r, got);
                vectors++;
                if (got !== r.exp) begin
                    miscompares++;
                    $display("FAIL reset dut%0d: got %h expected %h", d, got, r.exp);
                end
            end
        end
    endtask

    task automatic test_mem();
        out_t got;
        plan_reset(2);
        plan_instr(0, LW, 6'h00, 1'b0, 0, 0);
        plan_instr(0, SW, 6'h00, 1'b1, 0, 3);
        plan_instr(0, LW, 6'h00, 1'b1, 2, 3);
        while (plan_q.size() > 0) begin
            rec_t r = plan_q.pop_front();
            tick(0, r, got);
            vectors++;
            if (got !== r.exp) begin
                miscompares++;
                $display("FAIL lw_sw state %0d: got %h expected %h", r.exp.st, got, r.exp);
            end
        end
    endtask

    task automatic test_branch_alu();
        out_t got;
        for (int d = 0; d < 2; d++) begin
            plan_reset(2);
            plan_instr(d, BNE, 6'h00, 1'b0, 0, 0);
            plan_instr(d, BNE, 6'h00, 1'b1, 0, 0);
            plan_instr(d, BEQ, 6'h00, 1'b1, 0, 0);
            plan_instr(d, RT, 6'h2a, 1'b0, 0, 0);
            plan_instr(d, RT, 6'h00, 1'b0, 0, 0);
            plan_instr(d, ANDI, 6'h00, 1'b0, 0, 0);
            plan_instr(d, ORI, 6'h00, 1'b0, 0, 0);
            plan_instr(d, ADDI, 6'h00, 1'b0, 0, 0);
            while (plan_q.size() > 0) begin
                rec_t r = plan_q.pop_front();
                tick(d, r, got);
                vectors++;
                if (got !== r.exp) begin
                    miscompares++;
                    $display("FAIL branch_alu dut%0d op %h: got %h expected %h", d, r.op, got, r.exp);
                end
            end
        end
    endtask

    task automatic test_timeout();
        out_t got;
        plan_reset(2);
        plan_instr(0, ADDI, 6'h00, 1'b0, 4, 0);
        plan_instr(0, LW, 6'h00, 1'b0, 0, 4);
        plan_instr(0, SW, 6'h00, 1'b0, 0, 9);
        plan_instr(0, JMP, 6'h00, 1'b0, 3, 0);
        while (plan_q.size() > 0) begin
            rec_t r = plan_q.pop_front();
            tick(0, r, got);
            vectors++;
            if (got !== r.exp) begin
                miscompares++;
                $display("FAIL timeout state %0d: got %h expected %h", r.exp.st, got, r.exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_t got;
        rec_t last;
        plan_reset(2);
        plan_instr(0, LW, 6'h00, 1'b0, 0, 0);
        last = plan_q.pop_back();
        last.rst = 1'b0;
        last.exp = rst_vec();
        plan_q.push_back(last);
        plan_instr(0, JMP, 6'h00, 1'b0, 0, 0);
        while (plan_q.size() > 0) begin
            rec_t r = plan_q.pop_front();
            tick(0, r, got);
            vectors++;
            if (got !== r.exp) begin
                miscompares++;
                $display("FAIL reset_mid: got %h expected %h", got, r.exp);
            end
        end
    endtask

    task automatic test_random(input int n);
        out_t got;
        for (int d = 0; d < 2; d++) begin
            plan_reset(2);
            for (int i = 0; i < n; i++)
                plan_instr(d, pick_op(), pick_funct(), 1'($urandom),
                           $urandom_range(0, 4), $urandom_range(0, 4));
            while (plan_q.size() > 0) begin
                rec_t r = plan_q.pop_front();
                tick(d, r, got);
                vectors++;
                if (got !== r.exp) begin
                    miscompares++;
                    $display("FAIL random dut%0d op %h fn %h: got %h expected %h",
                             d, r.op, r.funct, got, r.exp);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset_v[d] = 1'b0; op_v[d] = '0; funct_v[d] = '0; zero_v[d] = 1'b0; rdy_v[d] = 1'b0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_mem();
        test_branch_alu();
        test_timeout();
        test_reset_mid();
        test_random(60);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
